mul_issue_ctrl: RTL and testbench

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_issue_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//
// Issue controller that sits between an operand stream and a multi-cycle
// 64x64 multiplier core. It accepts one operand pair at a time, holds the
// operands steady for the core, pulses a start request until the core
// reports busy, then waits for the core to come back idle. When the core
// finishes, the 128-bit product goes into a small result FIFO. If the core
// never finishes, a watchdog aborts the wait and raises a sticky error.
//
// Ports
//   clk        in   1    single clock, all state on the rising edge
//   nrst       in   1    asynchronous active-low reset
//   in_valid   in   1    operand pair offered
//   in_ready   out  1    operand pair accepted when in_valid & in_ready
//   in_a/in_b  in   64   operands
//   mul_a/b    out  64   operands held for the multiplier core
//   mul_start  out  1    start request, high for the whole ISSUE state
//   mul_ready  in   1    core idle flag, low while the core operates
//   mul_p      in   128  core product, valid when mul_ready returns high
//   out_valid  out  1    FIFO head valid
//   out_ready  in   1    consumer takes the head when out_valid & out_ready
//   out_p      out  128  FIFO head product
//   err        out  1    sticky watchdog timeout flag
//   done_cnt   out  16   completed-product counter, wraps
module mul_issue_ctrl #(
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  in_a,
   input  logic [63:0]  in_b,
   output logic [63:0]  mul_a,
   output logic [63:0]  mul_b,
   output logic         mul_start,
   input  logic         mul_ready,
   input  logic [127:0] mul_p,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_p,
   output logic         err,
   output logic [15:0]  done_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [TMO_W-1:0] LAST_WAIT = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [TMO_W-1:0] wait_cnt;
   logic [127:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic accept;
   logic timeout_hit;
   logic push;
   logic pop;

   // A new operation may only start when the core is idle and the FIFO
   // still has a free slot, so the result of the operation we are about to
   // start always has somewhere to land. Gating with nrst keeps in_ready low
   // for the whole time reset is held, not just after the first edge.
   always_comb begin
      in_ready  = 1'b0;
      mul_start = 1'b0;
      if (nrst && (state == IDLE) && mul_ready && (count < FULL_CNT))
         in_ready = 1'b1;
      if (state == ISSUE)
         mul_start = 1'b1;
   end

   assign accept      = in_valid & in_ready;
   assign timeout_hit = (state == WAIT) && !mul_ready && (wait_cnt == LAST_WAIT);
   assign push        = (state == WAIT) && mul_ready;
   assign pop         = out_valid & out_ready;
   assign out_valid   = (count != '0);
   assign out_p       = mem[rd_ptr];

   // State register for the issue sequence.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic. ISSUE holds the start request until the core shows
   // it has taken the operands by dropping mul_ready. WAIT leaves either on
   // completion or when the watchdog expires.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = ISSUE;
         ISSUE:   if (!mul_ready) state_next = WAIT;
         WAIT:    if (mul_ready || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand latches feeding the core. They only change on an accept so the
   // core sees stable operands for the whole operation.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mul_a <= '0;
         mul_b <= '0;
      end else if (accept) begin
         mul_a <= in_a;
         mul_b <= in_b;
      end
   end

   // Watchdog counter for the WAIT state. It is cleared while in ISSUE so it
   // starts from zero on entry to WAIT, and counts each WAIT cycle in which
   // the core is still busy.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         wait_cnt <= '0;
      else if (state == WAIT && !mul_ready && !timeout_hit)
         wait_cnt <= wait_cnt + TMO_W'(1);
      else
         wait_cnt <= '0;
   end

   // Sticky error: once the watchdog fires it stays set until reset, while
   // the controller itself goes back to normal operation.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         err <= 1'b0;
      else if (timeout_hit)
         err <= 1'b1;
   end

   // Completed-product counter, bumped on the same edge the product is
   // pushed. Aborted operations do not count.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         done_cnt <= '0;
      else if (push)
         done_cnt <= done_cnt + 16'd1;
   end

   // Result FIFO storage and pointers. Pointers wrap explicitly at DEPTH so
   // non-power-of-two depths work. Storage is cleared on reset so the head
   // output is a defined value even when the FIFO is empty.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= mul_p;
            wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
   end

   // Occupancy tracking. A push and a pop on the same edge cancel out.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         count <= '0;
      else begin
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl
//
// Directed bench for mul_issue_ctrl. A behavioural multiplier core stub
// models the radix-4 core timing (start sampled, then mul_ready low for 34
// cycles) and can be told to hang so the watchdog path is exercised.
module tb_mul_issue_ctrl;

   logic         clk;
   logic         nrst;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_a;
   logic [63:0]  in_b;
   logic [63:0]  mul_a;
   logic [63:0]  mul_b;
   logic         mul_start;
   logic         mul_ready;
   logic [127:0] mul_p;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_p;
   logic         err;
   logic [15:0]  done_cnt;

   int checkCount;
   int errorCount;

   logic stubHang;
   int   stubCnt;

   mul_issue_ctrl #(.DEPTH(2), .TIMEOUT(64)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_start (mul_start),
      .mul_ready (mul_ready),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .err       (err),
      .done_cnt  (done_cnt)
   );

   // 10 time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core stub: LOAD + BUSY + FINISH = 34 cycles with mul_ready low after the
   // start request is sampled. In hang mode mul_ready stays low until the
   // bench releases it.
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mul_ready <= 1'b1;
         mul_p     <= '0;
         stubCnt   <= 0;
      end else if (stubCnt > 0) begin
         if (stubCnt == 1)
            mul_ready <= 1'b1;
         stubCnt <= stubCnt - 1;
      end else if (!mul_ready) begin
         if (!stubHang)
            mul_ready <= 1'b1;
      end else if (mul_start) begin
         mul_ready <= 1'b0;
         mul_p     <= 128'(mul_a) * 128'(mul_b);
         stubCnt   <= stubHang ? 0 : 34;
      end
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Offers an operand pair until it is accepted (bounded). Returns at the
   // falling edge of cycle 1, cycle 0 being the accept cycle.
   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
      logic accepted;
      accepted = 1'b0;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !accepted; i++) begin
         if (in_ready)
            accepted = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checkOutput("accept", 128'(accepted), 128'd1);
   endtask

   // Counts cycles from cycle 1 until out_valid rises (bounded).
   task automatic waitValid(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic waitDone(input logic [15:0] target);
      for (int i = 0; i < 300 && done_cnt != target; i++)
         @(negedge clk);
      checkOutput("done_wait", 128'(done_cnt), 128'(target));
   endtask

   initial begin
      int  cyc;
      logic sawValid;
      logic sawReady;

      checkCount = 0;
      errorCount = 0;
      stubHang   = 1'b0;
      nrst       = 1'b0;
      in_valid   = 1'b0;
      in_a       = '0;
      in_b       = '0;
      out_ready  = 1'b0;

      // Reset state while nrst is held low.
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready",  128'(in_ready),  128'd0);
      checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
      checkOutput("rst_out_p",     out_p,           128'd0);
      checkOutput("rst_err",       128'(err),       128'd0);
      checkOutput("rst_done_cnt",  128'(done_cnt),  128'd0);
      checkOutput("rst_mul_start", 128'(mul_start), 128'd0);
      checkOutput("rst_mul_a",     128'(mul_a),     128'd0);
      nrst = 1'b1;
      @(negedge clk);
      checkOutput("idle_in_ready", 128'(in_ready), 128'd1);

      // Single operation 3*5 with consumer always ready.
      out_ready = 1'b1;
      applyStimulus(64'd3, 64'd5);
      checkOutput("t1_start_c1", 128'(mul_start), 128'd1);
      checkOutput("t1_mul_b",    128'(mul_b),     128'd5);
      @(negedge clk);
      checkOutput("t1_start_c2", 128'(mul_start), 128'd1);
      @(negedge clk);
      checkOutput("t1_start_c3", 128'(mul_start), 128'd0);
      waitValid(cyc);
      cyc = cyc + 2;
      checkOutput("t1_latency",  128'(cyc),       128'd37);
      checkOutput("t1_out_p",    out_p,           128'd15);
      checkOutput("t1_done_cnt", 128'(done_cnt),  128'd1);
      @(negedge clk);
      checkOutput("t1_popped",   128'(out_valid), 128'd0);

      // Two operations with the consumer stalled: FIFO fills, ordering kept.
      out_ready = 1'b0;
      applyStimulus(64'hFFFF_FFFF, 64'h1_0000_0000);
      waitValid(cyc);
      checkOutput("t2_latency",   128'(cyc),      128'd37);
      checkOutput("t2_head1",     out_p,          128'hFFFF_FFFF_0000_0000);
      checkOutput("t2_b2b_ready", 128'(in_ready), 128'd1);
      applyStimulus(64'd7, 64'd9);
      waitDone(16'd3);
      sawReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (in_ready) sawReady = 1'b1;
         @(negedge clk);
      end
      checkOutput("t2_full_ready", 128'(sawReady),  128'd0);
      checkOutput("t2_full_valid", 128'(out_valid), 128'd1);
      checkOutput("t2_full_head",  out_p,           128'hFFFF_FFFF_0000_0000);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("t2_head2",      out_p,          128'd63);
      checkOutput("t2_ready_back", 128'(in_ready), 128'd1);

      // Re-accept right after the pop, then drain both in order.
      applyStimulus(64'd2, 64'd3);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("t3_drained", 128'(out_valid), 128'd0);
      waitValid(cyc);
      checkOutput("t3_out_p",    out_p,          128'd6);
      checkOutput("t3_done_cnt", 128'(done_cnt), 128'd4);

      // Hung core: watchdog fires after 64 WAIT cycles, nothing pushed.
      @(negedge clk);
      stubHang = 1'b1;
      applyStimulus(64'd11, 64'd13);
      cyc = 1;
      while (!err && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("t4_err_cycle", 128'(cyc),       128'd67);
      checkOutput("t4_no_push",   128'(out_valid), 128'd0);
      checkOutput("t4_done_cnt",  128'(done_cnt),  128'd4);
      stubHang = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("t4_idle_ready", 128'(in_ready), 128'd1);
      applyStimulus(64'd4, 64'd5);
      waitValid(cyc);
      checkOutput("t4_latency",  128'(cyc),      128'd37);
      checkOutput("t4_out_p",    out_p,          128'd20);
      checkOutput("t4_done_cnt2", 128'(done_cnt), 128'd5);
      checkOutput("t4_err_stick", 128'(err),      128'd1);
      @(negedge clk);

      // Reset asserted in cycle 20 of an operation.
      applyStimulus(64'd9, 64'd9);
      repeat (19) @(negedge clk);
      nrst = 1'b0;
      #1;
      checkOutput("t5_in_ready",  128'(in_ready),  128'd0);
      checkOutput("t5_start",     128'(mul_start), 128'd0);
      checkOutput("t5_out_valid", 128'(out_valid), 128'd0);
      checkOutput("t5_out_p",     out_p,           128'd0);
      checkOutput("t5_err",       128'(err),       128'd0);
      checkOutput("t5_done_cnt",  128'(done_cnt),  128'd0);
      checkOutput("t5_mul_a",     128'(mul_a),     128'd0);
      @(negedge clk);
      nrst = 1'b1;
      sawValid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (out_valid) sawValid = 1'b1;
         @(negedge clk);
      end
      checkOutput("t5_no_result", 128'(sawValid), 128'd0);
      applyStimulus(64'd6, 64'd7);
      waitValid(cyc);
      checkOutput("t5_latency",  128'(cyc),      128'd37);
      checkOutput("t5_out_p",    out_p,          128'd42);
      checkOutput("t5_done_after", 128'(done_cnt), 128'd1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
